// File: rtl/limbus_dbg_pkg.sv
// Shared types and constants for the limbus debug scan bridge.
package limbus_dbg_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  localparam int unsigned ST_VALID = 0;
  localparam int unsigned ST_OVR   = 1;

  // Number of capture channels addressable by an IR of the given width.
  function automatic int unsigned num_ch(input int unsigned ir_w);
    return 32'd1 << ir_w;
  endfunction

endpackage

// File: rtl/limbus_dbg_scan_bridge_if.sv
// Action channel from the scan bridge toward the debug core (valid/ready).
interface limbus_dbg_scan_bridge_if #(
  parameter int unsigned IR_W = 2,
  parameter int unsigned DR_W = 38
) ();

  logic            act_valid;
  logic            act_ready;
  logic [IR_W-1:0] act_ch;
  logic [DR_W-1:0] jdo;
  logic            act_partial;

  modport master (
    output act_valid,
    output act_ch,
    output jdo,
    output act_partial,
    input  act_ready
  );

  modport slave (
    input  act_valid,
    input  act_ch,
    input  jdo,
    input  act_partial,
    output act_ready
  );

endinterface

// File: rtl/limbus_dbg_shift_reg.sv
// Data-register scan chain: parallel capture, LSB-out shift and a saturating bit counter.
module limbus_dbg_shift_reg #(
  parameter  int unsigned DR_W  = 38,
  localparam int unsigned CNT_W = $clog2(DR_W + 2)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [DR_W-1:0]  load_data,
  input  logic             tdi,
  output logic [DR_W-1:0]  sr,
  output logic [CNT_W-1:0] cnt
);

  // One past a full scan, so over-length scans stay distinguishable from exact ones.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DR_W + 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_data;
      cnt <= '0;
    end else if (shift) begin
      sr <= {tdi, sr[DR_W-1:1]};
      if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/limbus_dbg_scan_bridge.sv
// Virtual-JTAG scan bridge: IR latch, DR scan sequencing and a valid/ready action
// register with sticky overrun and scan-length reporting.
module limbus_dbg_scan_bridge
  import limbus_dbg_pkg::*;
#(
  parameter  int unsigned IR_W   = 2,
  parameter  int unsigned DR_W   = 38,
  localparam int unsigned NUM_CH = num_ch(IR_W),
  localparam int unsigned CNT_W  = $clog2(DR_W + 2)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tck_en,
  input  logic                     tdi,
  input  logic [IR_W-1:0]          ir_in,
  input  logic                     vs_uir,
  input  logic                     vs_cdr,
  input  logic                     vs_sdr,
  input  logic                     vs_udr,
  input  logic [NUM_CH*DR_W-1:0]   cap_data,
  input  logic                     ovr_clr,
  output logic                     tdo,
  output logic [IR_W-1:0]          ir_out,
  output logic                     overrun,
  limbus_dbg_scan_bridge_if.master act
);

  state_t           state_q, state_d;
  logic [IR_W-1:0]  ir_reg;
  logic [DR_W-1:0]  sr;
  logic [CNT_W-1:0] cnt;
  logic             sr_load, sr_shift, dr_update;
  logic             ev_uir, ev_cdr, ev_sdr, ev_udr;
  logic             accept, drop;
  logic             act_valid_q, act_partial_q, overrun_q;
  logic [IR_W-1:0]  act_ch_q;
  logic [DR_W-1:0]  jdo_q;
  logic [DR_W-1:0]  cap_words [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_cap
    assign cap_words[k] = cap_data[k*DR_W +: DR_W];
  end

  // Qualified, mutually exclusive events: uir > cdr > sdr > udr.
  assign ev_uir = tck_en & vs_uir;
  assign ev_cdr = tck_en & vs_cdr & ~vs_uir;
  assign ev_sdr = tck_en & vs_sdr & ~vs_uir & ~vs_cdr;
  assign ev_udr = tck_en & vs_udr & ~vs_uir & ~vs_cdr & ~vs_sdr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_reg <= '0;
    end else if (ev_uir) begin
      ir_reg <= ir_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    dr_update = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev_cdr) begin
          sr_load = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (ev_cdr) begin
          sr_load = 1'b1;
        end else if (ev_sdr) begin
          sr_shift = 1'b1;
        end else if (ev_udr) begin
          dr_update = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  limbus_dbg_shift_reg #(.DR_W(DR_W)) u_shift_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (sr_load),
    .shift     (sr_shift),
    .load_data (cap_words[ir_reg]),
    .tdi       (tdi),
    .sr        (sr),
    .cnt       (cnt)
  );

  // An update loads only if the slot is free or being drained this same cycle.
  assign accept = dr_update & (~act_valid_q | act.act_ready);
  assign drop   = dr_update & act_valid_q & ~act.act_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_valid_q <= 1'b0;
    end else if (accept) begin
      act_valid_q <= 1'b1;
    end else if (act_valid_q && act.act_ready) begin
      act_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo_q         <= '0;
      act_ch_q      <= '0;
      act_partial_q <= 1'b0;
    end else if (accept) begin
      jdo_q         <= sr;
      act_ch_q      <= ir_reg;
      act_partial_q <= (cnt != CNT_W'(DR_W));
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (ovr_clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign act.act_valid   = act_valid_q;
  assign act.act_ch      = act_ch_q;
  assign act.jdo         = jdo_q;
  assign act.act_partial = act_partial_q;
  assign overrun         = overrun_q;
  assign tdo             = sr[0];

  always_comb begin
    ir_out           = '0;
    ir_out[ST_VALID] = act_valid_q;
    ir_out[ST_OVR]   = overrun_q;
  end

endmodule

// File: tb/tb_limbus_dbg_scan_bridge.sv
// Randomized scoreboard bench for limbus_dbg_scan_bridge with a behavioural scan model.
module tb_limbus_dbg_scan_bridge;

  localparam int unsigned IR_W   = 2;
  localparam int unsigned DR_W   = 38;
  localparam int unsigned NUM_CH = 1 << IR_W;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   tck_en, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, ovr_clr;
  logic [IR_W-1:0]        ir_in;
  logic [NUM_CH*DR_W-1:0] cap_data;
  logic                   tdo, overrun;
  logic [IR_W-1:0]        ir_out;

  limbus_dbg_scan_bridge_if #(.IR_W(IR_W), .DR_W(DR_W)) act_if ();

  limbus_dbg_scan_bridge #(.IR_W(IR_W), .DR_W(DR_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tck_en   (tck_en),
    .tdi      (tdi),
    .ir_in    (ir_in),
    .vs_uir   (vs_uir),
    .vs_cdr   (vs_cdr),
    .vs_sdr   (vs_sdr),
    .vs_udr   (vs_udr),
    .cap_data (cap_data),
    .ovr_clr  (ovr_clr),
    .tdo      (tdo),
    .ir_out   (ir_out),
    .overrun  (overrun),
    .act      (act_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DR_W-1:0] data;
    logic [IR_W-1:0] ch;
    logic            partial;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state: latched IR, chain contents, bits shifted, scan-open flag, action slot.
  logic [IR_W-1:0] m_ir    = '0;
  logic [DR_W-1:0] m_sr    = '0;
  int              m_cnt   = 0;
  bit              m_scan  = 1'b0;
  bit              m_valid = 1'b0;
  bit              m_ovr   = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [DR_W-1:0] cap_word(input logic [IR_W-1:0] ch);
    return cap_data[int'(ch)*DR_W +: DR_W];
  endfunction

  // One clock of stimulus; the model advances for the same edge, then state is compared.
  task automatic cyc(input bit t, input bit u, input bit c, input bit s, input bit d,
                     input bit ti, input bit rdy, input bit clr);
    bit upd  = 1'b0;
    bit drop = 1'b0;
    tck_en = t; vs_uir = u; vs_cdr = c; vs_sdr = s; vs_udr = d;
    tdi = ti; act_if.act_ready = rdy; ovr_clr = clr;
    if (t && u) m_ir = ir_in;
    else if (t && c) begin
      m_sr = cap_word(m_ir); m_cnt = 0; m_scan = 1'b1;
    end else if (t && s) begin
      if (m_scan) begin
        m_sr = (m_sr >> 1) | (DR_W'(ti) << (DR_W - 1));
        if (m_cnt < int'(DR_W) + 1) m_cnt++;
      end
    end else if (t && d && m_scan) begin
      m_scan = 1'b0; upd = 1'b1;
    end
    if (upd) begin
      if (!m_valid || rdy) begin
        q.push_back(exp_t'{data: m_sr, ch: m_ir, partial: (m_cnt != int'(DR_W))});
        m_valid = 1'b1;
      end else drop = 1'b1;
    end else if (m_valid && rdy) m_valid = 1'b0;
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    @(posedge clk); #1;
    check("tdo", 64'(tdo), 64'(m_sr[0]));
    check("act_valid", 64'(act_if.act_valid), 64'(m_valid));
    check("overrun", 64'(overrun), 64'(m_ovr));
    check("ir_out", 64'(ir_out), 64'({m_ovr, m_valid}));
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rdy, 1'b0);
  endtask

  task automatic set_ir(input logic [IR_W-1:0] v, input bit rdy);
    ir_in = v;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic scan(input int n, input logic [63:0] bits, input bit rdy, input bit rdy_udr,
                      input bit gaps);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(rdy, int'($urandom_range(1, 3)));
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, bits[i], rdy, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rdy_udr, 1'b0);
  endtask

  task automatic randomize_caps();
    for (int k = 0; k < int'(NUM_CH); k++)
      cap_data[k*DR_W +: DR_W] = DR_W'({$urandom, $urandom});
  endtask

  // Scoreboard: whenever an action is presented it must match the oldest expected one.
  always @(negedge clk) begin
    if (reset_n && act_if.act_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL act_unexpected: got jdo %0h expected no action at %0t", act_if.jdo, $time);
      end else begin
        check("act_jdo", 64'(act_if.jdo), 64'(q[0].data));
        check("act_ch", 64'(act_if.act_ch), 64'(q[0].ch));
        check("act_partial", 64'(act_if.act_partial), 64'(q[0].partial));
        if (act_if.act_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [DR_W-1:0] ser;
    logic [DR_W-1:0] w;
    logic [63:0]     bits_a, bits_b;
    logic [4:0]      b5;
    int              n;

    reset_n = 1'b0; tck_en = 1'b0; tdi = 1'b0; vs_uir = 1'b0; vs_cdr = 1'b0;
    vs_sdr = 1'b0; vs_udr = 1'b0; ovr_clr = 1'b0; ir_in = '0; act_if.act_ready = 1'b0;
    randomize_caps();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tdo", 64'(tdo), 64'd0);
    check("rst_ir_out", 64'(ir_out), 64'd0);
    check("rst_valid", 64'(act_if.act_valid), 64'd0);
    check("rst_jdo", 64'(act_if.jdo), 64'd0);
    check("rst_ch", 64'(act_if.act_ch), 64'd0);
    check("rst_partial", 64'(act_if.act_partial), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    reset_n = 1'b1;

    // Full scan of channel 2 with tdi held high.
    cap_data[2*DR_W +: DR_W] = 38'h2_1234_5678;
    set_ir(2'd2, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ser[0] = tdo;
    for (int i = 1; i < int'(DR_W); i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      ser[i] = tdo;
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("full_serial", 64'(ser), 64'h2_1234_5678);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("full_jdo", 64'(act_if.jdo), 64'h3F_FFFF_FFFF);
    check("full_ch", 64'(act_if.act_ch), 64'd2);
    check("full_partial", 64'(act_if.act_partial), 64'd0);
    idle(1'b1, 1);

    // Short scan of five bits.
    w  = cap_word(2'd2);
    b5 = 5'b10110;
    scan(5, 64'(b5), 1'b0, 1'b0, 1'b0);
    check("short_jdo", 64'(act_if.jdo), 64'((w >> 5) | (DR_W'(b5) << (DR_W - 5))));
    check("short_partial", 64'(act_if.act_partial), 64'd1);
    idle(1'b1, 1);

    // Overrun: second scan dropped while the first is still pending.
    bits_a = {$urandom, $urandom};
    bits_b = ~bits_a;
    scan(int'(DR_W), bits_a, 1'b0, 1'b0, 1'b1);
    scan(int'(DR_W), bits_b, 1'b0, 1'b0, 1'b1);
    check("ovr_jdo_kept", 64'(act_if.jdo), 64'(bits_a[DR_W-1:0]));
    check("ovr_flag", 64'(overrun), 64'd1);
    check("ovr_ir_out", 64'(ir_out), 64'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_cleared", 64'(overrun), 64'd0);
    check("ovr_clr_ir_out", 64'(ir_out), 64'd1);
    idle(1'b1, 1);

    // Same-cycle accept: ready in the update cycle replaces the pending action.
    scan(int'(DR_W), bits_a, 1'b0, 1'b0, 1'b0);
    scan(int'(DR_W), bits_b, 1'b0, 1'b1, 1'b0);
    check("acc_valid", 64'(act_if.act_valid), 64'd1);
    check("acc_overrun", 64'(overrun), 64'd0);
    check("acc_jdo", 64'(act_if.jdo), 64'(bits_b[DR_W-1:0]));
    idle(1'b1, 1);

    // Qualification and priority.
    ir_in = 2'd3;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("unqual_valid", 64'(act_if.act_valid), 64'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("prio_tdo", 64'(tdo), 64'(cap_data[2*DR_W]));
    check("prio_valid", 64'(act_if.act_valid), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("prio_upd_jdo", 64'(act_if.jdo), 64'(cap_word(2'd2)));
    idle(1'b1, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("udr_no_cap", 64'(act_if.act_valid), 64'd0);

    // Async reset mid-shift with an action pending.
    scan(int'(DR_W), bits_a, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_tdo", 64'(tdo), 64'd0);
    check("arst_ir_out", 64'(ir_out), 64'd0);
    check("arst_valid", 64'(act_if.act_valid), 64'd0);
    check("arst_jdo", 64'(act_if.jdo), 64'd0);
    check("arst_ch", 64'(act_if.act_ch), 64'd0);
    check("arst_partial", 64'(act_if.act_partial), 64'd0);
    check("arst_overrun", 64'(overrun), 64'd0);
    m_ir = '0; m_sr = '0; m_cnt = 0; m_scan = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
    q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    scan(int'(DR_W), bits_b, 1'b0, 1'b1, 1'b0);
    check("post_rst_jdo", 64'(act_if.jdo), 64'(bits_b[DR_W-1:0]));
    check("post_rst_ch", 64'(act_if.act_ch), 64'd0);
    idle(1'b1, 1);

    // Randomized scans, lengths, channels, gaps, back-pressure and overrun clears.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) randomize_caps();
      if ($urandom_range(0, 2) == 0) set_ir(IR_W'($urandom), 1'($urandom));
      n = ($urandom_range(0, 1) == 1) ? int'(DR_W) : int'($urandom_range(0, DR_W + 4));
      scan(n, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b1);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--)
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    idle(1'b1, 3);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
